// File: rtl/cmac_mon_pkg.sv
// rtl/cmac_mon_pkg.sv - shared constants, types and saturating helpers for the CMAC RX monitor
package cmac_mon_pkg;

   localparam int unsigned CMAC_GT_CLK_FREQ     = 322_266_000;
   localparam int unsigned CMAC_MIN_FRAME_BYTES = 64;
   localparam int unsigned CMAC_MAX_FRAME_BYTES = 9600;

   typedef enum logic {
      FRM_IDLE     = 1'b0,
      FRM_IN_FRAME = 1'b1
   } frm_state_e;

   typedef struct packed {
      logic [63:0] speed;
      logic [31:0] pkt;
      logic [31:0] err;
      logic [31:0] runt;
      logic [31:0] oversize;
   } cmac_stats_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] a, input logic inc);
      return (inc && (a != 32'hFFFF_FFFF)) ? a + 32'd1 : a;
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
      logic [64:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
   endfunction

endpackage

// File: rtl/cmac_keep_popcnt.sv
// rtl/cmac_keep_popcnt.sv - combinational count of set byte enables in a 64-byte beat
module cmac_keep_popcnt (
   input  logic [63:0] keep_i,
   output logic [6:0]  cnt_o
);

   logic [6:0] acc;

   always_comb begin
      acc = '0;
      for (int i = 0; i < 64; i++) begin
         acc = acc + {6'd0, keep_i[i]};
      end
      cnt_o = acc;
   end

endmodule

// File: rtl/cmac_rx_monitor.sv
// rtl/cmac_rx_monitor.sv - per-window byte, frame, error, runt and oversize statistics for the CMAC RX stream
module cmac_rx_monitor
   import cmac_mon_pkg::*;
#(
   parameter int unsigned GT_CLK_FREQ     = CMAC_GT_CLK_FREQ,
   parameter int unsigned MIN_FRAME_BYTES = CMAC_MIN_FRAME_BYTES,
   parameter int unsigned MAX_FRAME_BYTES = CMAC_MAX_FRAME_BYTES
) (
   input  logic        gt_clk,
   input  logic        sys_reset,
   input  logic        rx_usr_axis_tvalid,
   input  logic        rx_usr_axis_tlast,
   input  logic [63:0] rx_usr_axis_tkeep,
   input  logic        rx_usr_axis_tuser,
   output logic [63:0] cmac_rx_speed_reg,
   output logic [31:0] cmac_rx_pkt_reg,
   output logic [31:0] cmac_rx_err_reg,
   output logic [31:0] cmac_rx_runt_reg,
   output logic [31:0] cmac_rx_oversize_reg,
   output logic        cmac_rx_stat_vld
);

   localparam logic [31:0] WIN_LAST = 32'(GT_CLK_FREQ - 1);

   logic [6:0]  keep_cnt;

   logic        s1_vld_q, s1_last_q, s1_user_q;
   logic [6:0]  s1_cnt_q;

   frm_state_e  state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [31:0] win_cnt_q, win_cnt_d;
   cmac_stats_t acc_q, acc_d, out_q, out_d;
   logic        stat_vld_q, stat_vld_d;

   logic        terminal;
   logic        frame_done;
   logic [15:0] cur_len;
   cmac_stats_t acc_nxt;

   cmac_keep_popcnt u_popcnt (
      .keep_i (rx_usr_axis_tkeep),
      .cnt_o  (keep_cnt)
   );

   always_ff @(posedge gt_clk) begin
      if (sys_reset) begin
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_user_q <= 1'b0;
         s1_cnt_q  <= '0;
      end else begin
         s1_vld_q  <= rx_usr_axis_tvalid;
         s1_last_q <= rx_usr_axis_tlast;
         s1_user_q <= rx_usr_axis_tuser;
         s1_cnt_q  <= keep_cnt;
      end
   end

   always_ff @(posedge gt_clk) begin
      if (sys_reset) begin
         state_q <= FRM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FRM_IDLE:     if (s1_vld_q && !s1_last_q) state_d = FRM_IN_FRAME;
         FRM_IN_FRAME: if (s1_vld_q && s1_last_q)  state_d = FRM_IDLE;
         default:      state_d = FRM_IDLE;
      endcase
   end

   // Length includes the beat in stage 1, so a completing beat is judged on its full frame.
   always_comb begin
      terminal   = (win_cnt_q == WIN_LAST);
      win_cnt_d  = terminal ? 32'd0 : win_cnt_q + 32'd1;
      frame_done = s1_vld_q && s1_last_q;
      cur_len    = (state_q == FRM_IDLE) ? {9'd0, s1_cnt_q} : sat_add16(len_q, {9'd0, s1_cnt_q});
      len_d      = s1_vld_q ? cur_len : len_q;

      acc_nxt.speed    = sat_add64(acc_q.speed, s1_vld_q ? {54'd0, s1_cnt_q, 3'b000} : 64'd0);
      acc_nxt.pkt      = sat_inc32(acc_q.pkt, frame_done);
      acc_nxt.err      = sat_inc32(acc_q.err, frame_done && s1_user_q);
      acc_nxt.runt     = sat_inc32(acc_q.runt, frame_done && ({16'd0, cur_len} < MIN_FRAME_BYTES));
      acc_nxt.oversize = sat_inc32(acc_q.oversize, frame_done && ({16'd0, cur_len} > MAX_FRAME_BYTES));

      acc_d      = acc_nxt;
      out_d      = out_q;
      stat_vld_d = 1'b0;
      // The terminal-cycle increment goes into the closing window, never into the cleared accumulator.
      if (terminal) begin
         out_d      = acc_nxt;
         acc_d      = '0;
         stat_vld_d = 1'b1;
      end
   end

   always_ff @(posedge gt_clk) begin
      if (sys_reset) begin
         win_cnt_q  <= '0;
         len_q      <= '0;
         acc_q      <= '0;
         out_q      <= '0;
         stat_vld_q <= 1'b0;
      end else begin
         win_cnt_q  <= win_cnt_d;
         len_q      <= len_d;
         acc_q      <= acc_d;
         out_q      <= out_d;
         stat_vld_q <= stat_vld_d;
      end
   end

   assign cmac_rx_speed_reg    = out_q.speed;
   assign cmac_rx_pkt_reg      = out_q.pkt;
   assign cmac_rx_err_reg      = out_q.err;
   assign cmac_rx_runt_reg     = out_q.runt;
   assign cmac_rx_oversize_reg = out_q.oversize;
   assign cmac_rx_stat_vld     = stat_vld_q;

endmodule

// File: tb/tb_cmac_rx_monitor.sv
// tb/tb_cmac_rx_monitor.sv - self-checking bench for cmac_rx_monitor with a window-level reference model
module tb_cmac_rx_monitor;
   import cmac_mon_pkg::*;

   localparam int F = 100;
   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] HALF = 64'h0000_0000_FFFF_FFFF;

   logic        gt_clk = 1'b0;
   logic        sys_reset = 1'b1;
   logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
   logic [63:0] tkeep = '0;
   logic [63:0] speed_o;
   logic [31:0] pkt_o, err_o, runt_o, over_o;
   logic        vld_o;

   cmac_rx_monitor #(.GT_CLK_FREQ(F)) dut (
      .gt_clk               (gt_clk),
      .sys_reset            (sys_reset),
      .rx_usr_axis_tvalid   (tvalid),
      .rx_usr_axis_tlast    (tlast),
      .rx_usr_axis_tkeep    (tkeep),
      .rx_usr_axis_tuser    (tuser),
      .cmac_rx_speed_reg    (speed_o),
      .cmac_rx_pkt_reg      (pkt_o),
      .cmac_rx_err_reg      (err_o),
      .cmac_rx_runt_reg     (runt_o),
      .cmac_rx_oversize_reg (over_o),
      .cmac_rx_stat_vld     (vld_o)
   );

   always #5 gt_clk = ~gt_clk;

   int          total = 0, bad = 0, cyc = 0, m_len = 0, npulse = 0;
   logic        m_in = 1'b0;
   cmac_stats_t mw [16];
   cmac_stats_t exp_cur, snap [2];

   typedef struct {
      int          nb;
      logic [63:0] lkeep;
      logic        usr;
      cmac_stats_t w0;
      cmac_stats_t w1;
   } vec_t;
   vec_t vt [6];

   function automatic cmac_stats_t st(input logic [63:0] s, input int p, input int e, input int r, input int o);
      cmac_stats_t x;
      x.speed = s; x.pkt = 32'(p); x.err = 32'(e); x.runt = 32'(r); x.oversize = 32'(o);
      return x;
   endfunction

   function automatic cmac_stats_t dut_stats();
      return st(speed_o, int'(pkt_o), int'(err_o), int'(runt_o), int'(over_o));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_stats(input string nm, input cmac_stats_t a, input cmac_stats_t e);
      chk({nm, "_speed"}, a.speed, e.speed);
      chk({nm, "_pkt"}, {32'd0, a.pkt}, {32'd0, e.pkt});
      chk({nm, "_err"}, {32'd0, a.err}, {32'd0, e.err});
      chk({nm, "_runt"}, {32'd0, a.runt}, {32'd0, e.runt});
      chk({nm, "_oversize"}, {32'd0, a.oversize}, {32'd0, e.oversize});
   endtask

   // Reference: a beat sampled in cycle N lands in window (N+1)/F; frames close in their last beat's window.
   task automatic model_beat(input logic l, input logic [63:0] k, input logic u);
      int w, n;
      w = (cyc + 1) / F;
      n = $countones(k);
      m_len = m_in ? ((m_len + n > 65535) ? 65535 : m_len + n) : n;
      if (w < 16) begin
         mw[w].speed = mw[w].speed + 64'(n * 8);
         if (l) begin
            mw[w].pkt = mw[w].pkt + 1;
            if (u) mw[w].err = mw[w].err + 1;
            if (m_len < 64) mw[w].runt = mw[w].runt + 1;
            if (m_len > 9600) mw[w].oversize = mw[w].oversize + 1;
         end
      end
      m_in = !l;
   endtask

   task automatic step(input logic v, input logic l, input logic [63:0] k, input logic u);
      logic vexp;
      tvalid = v; tlast = l; tkeep = k; tuser = u;
      @(posedge gt_clk);
      if (v) model_beat(l, k, u);
      cyc++;
      #1;
      vexp = ((cyc % F) == 0);
      if (vexp && (cyc / F) <= 16) exp_cur = mw[cyc / F - 1];
      chk("stat_vld", {63'd0, vld_o}, {63'd0, vexp});
      chk_stats("out", dut_stats(), exp_cur);
      if (vld_o) npulse++;
      if (cyc == F) snap[0] = dut_stats();
      if (cyc == 2 * F) snap[1] = dut_stats();
   endtask

   task automatic idle_to(input int c);
      while (cyc < c) step(1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tkeep = '0;
      sys_reset = 1'b1;
      repeat (n) @(posedge gt_clk);
      #1;
      sys_reset = 1'b0;
      cyc = 0; m_in = 1'b0; m_len = 0; npulse = 0;
      exp_cur = '0;
      foreach (mw[j]) mw[j] = '0;
      chk("reset_vld", {63'd0, vld_o}, 64'd0);
      chk_stats("reset", dut_stats(), '0);
   endtask

   initial begin
      vt[0] = '{10,  ALL1, 1'b0, st(64'd5120, 1, 0, 0, 0),  st(64'd0, 0, 0, 0, 0)};
      vt[1] = '{1,   HALF, 1'b0, st(64'd256, 1, 0, 1, 0),   st(64'd0, 0, 0, 0, 0)};
      vt[2] = '{151, ALL1, 1'b1, st(64'd50688, 0, 0, 0, 0), st(64'd26624, 1, 1, 0, 1)};
      vt[3] = '{2,   64'd0, 1'b0, st(64'd512, 1, 0, 0, 0),  st(64'd0, 0, 0, 0, 0)};
      vt[4] = '{1,   64'd0, 1'b1, st(64'd0, 1, 1, 1, 0),    st(64'd0, 0, 0, 0, 0)};
      vt[5] = '{151, 64'd0, 1'b0, st(64'd50688, 0, 0, 0, 0), st(64'd26112, 1, 0, 0, 0)};

      for (int i = 0; i < 6; i++) begin
         do_reset(2);
         for (int b = 0; b < vt[i].nb; b++) begin
            step(1'b1, b == vt[i].nb - 1, (b == vt[i].nb - 1) ? vt[i].lkeep : ALL1,
                 (b == vt[i].nb - 1) && vt[i].usr);
         end
         idle_to(2 * F);
         chk_stats($sformatf("vec%0d_w0", i), snap[0], vt[i].w0);
         chk_stats($sformatf("vec%0d_w1", i), snap[1], vt[i].w1);
      end

      // Beats straddling the terminal cycle.
      do_reset(2);
      idle_to(F - 2);
      step(1'b1, 1'b1, ALL1, 1'b0);
      step(1'b1, 1'b1, ALL1, 1'b0);
      idle_to(2 * F);
      chk_stats("edge_w0", snap[0], st(64'd512, 1, 0, 0, 0));
      chk_stats("edge_w1", snap[1], st(64'd512, 1, 0, 0, 0));

      // Reset mid-frame discards the partial frame.
      do_reset(2);
      repeat (10) step(1'b1, 1'b0, ALL1, 1'b0);
      step(1'b1, 1'b1, ALL1, 1'b0);
      idle_to(F + 1);
      repeat (3) step(1'b1, 1'b0, ALL1, 1'b0);
      do_reset(1);
      step(1'b1, 1'b1, ALL1, 1'b0);
      idle_to(F);
      chk_stats("rst_full", snap[0], st(64'd512, 1, 0, 0, 0));
      repeat (3) step(1'b1, 1'b0, ALL1, 1'b0);
      do_reset(1);
      step(1'b1, 1'b1, HALF, 1'b0);
      idle_to(F);
      chk_stats("rst_runt", snap[0], st(64'd256, 1, 0, 1, 0));

      // Three empty windows.
      do_reset(2);
      idle_to(3 * F);
      chk("idle_pulses", 64'(npulse), 64'd3);

      // Randomized traffic against the model.
      do_reset(2);
      while (cyc < 750) begin
         int gap, nb, r;
         logic [63:0] k;
         gap = $urandom_range(0, 3);
         repeat (gap) step(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
         nb = ($urandom_range(0, 7) == 0) ? $urandom_range(140, 160) : $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            r = $urandom_range(0, 3);
            case (r)
               0:       k = ALL1;
               1:       k = {$urandom, $urandom};
               2:       k = 64'd0;
               default: k = ALL1 >> $urandom_range(0, 63);
            endcase
            step(1'b1, b == nb - 1, k, 1'($urandom_range(0, 1)));
         end
      end
      repeat (2) step(1'b0, 1'b0, '0, 1'b0);
      while ((cyc % F) != 0) step(1'b0, 1'b0, '0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
